// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-side front end for the 32x32 GPR file.
// Merges the in-order pipeline writeback and a long-latency result stream
// (valid/ready, buffered in a DEPTH-entry FIFO) onto the single write port.
// Pipeline writes always win the slot; queued results drain on idle cycles.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   p_we/p_waddr/p_wdata        pipeline writeback
//   b_valid/b_ready/b_waddr/b_wdata  long-latency result handshake
//   raddr1/raddr2, pend1/pend2  decode read addresses / pending-write hits (comb)
//   we/waddr/wdata              registered register-file write port
//   count                       FIFO occupancy (squashed entries included)
module reg_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         p_we,
  input  logic [AW-1:0]                p_waddr,
  input  logic [DW-1:0]                p_wdata,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [AW-1:0]                b_waddr,
  input  logic [DW-1:0]                b_wdata,
  input  logic [AW-1:0]                raddr1,
  input  logic [AW-1:0]                raddr2,
  output logic                         pend1,
  output logic                         pend2,
  output logic                         we,
  output logic [AW-1:0]                waddr,
  output logic [DW-1:0]                wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    q_addr [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic pw;
  logic push;
  logic pop;

  // Writes to r0 are architecturally discarded, so they never claim the slot.
  assign pw      = p_we && (p_waddr != '0);
  // Ready looks only at registered occupancy; a same-cycle pop does not help.
  assign b_ready = (count < CW'(DEPTH));
  assign push    = b_valid && b_ready;
  assign pop     = !pw && (count != '0);

  // FIFO, squash tracking and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      we <= 1'b0;
      if (pw) begin
        we    <= 1'b1;
        waddr <= p_waddr;
        wdata <= p_wdata;
      end else if (pop) begin
        // Squashed heads still pop, just without a write.
        we    <= q_live[head];
        waddr <= q_addr[head];
        wdata <= q_data[head];
      end

      // Pipeline write is younger than anything queued: kill older matches.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (pw && (q_addr[i] == p_waddr)) begin
          q_live[i] <= 1'b0;
        end
      end

      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= PW'(head + PW'(1));
      end

      // Push after the squash loop; an entry pushed alongside a matching
      // pipeline write is born dead. Push and pop never share a slot here.
      if (push) begin
        q_addr[tail] <= b_waddr;
        q_data[tail] <= b_wdata;
        q_live[tail] <= (b_waddr != '0) && !(pw && (b_waddr == p_waddr));
        tail         <= PW'(tail + PW'(1));
      end

      case ({push, pop})
        2'b10:   count <= CW'(count + CW'(1));
        2'b01:   count <= CW'(count - CW'(1));
        default: count <= count;
      endcase
    end
  end

  // Pending-write hits against live queued entries.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (q_live[i] && (raddr1 != '0) && (q_addr[i] == raddr1)) pend1 = 1'b1;
      if (q_live[i] && (raddr2 != '0) && (q_addr[i] == raddr2)) pend2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter: table-driven cycle vectors plus hand-written
// sequences; a scoreboard queue holds the expected write-port stream.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend1;
  logic        pend2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_we;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_p1;
    logic        e_p2;
  } vec_t;
  vec_t vt[11];

  reg_wb_arbiter #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2),
    .we(we), .waddr(waddr), .wdata(wdata), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic e_we, input logic [2:0] e_cnt, input logic e_rdy,
                              input logic e_p1, input logic e_p2);
    vec_t v;
    v.pw = pw; v.pa = pa; v.pd = pd; v.bv = bv; v.ba = ba; v.bd = bd;
    v.r1 = r1; v.r2 = r2; v.e_we = e_we; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
    v.e_p1 = e_p1; v.e_p2 = e_p2;
    return v;
  endfunction

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    p_we = pw; p_waddr = pa; p_wdata = pd;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    raddr1 = 5'd0;
    raddr2 = 5'd0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic wr_t mkw(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Write-port monitor: every issued write must match the scoreboard head.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      chk("we_addr_nonzero", 32'(waddr != 5'd0), 32'd1);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write at %0t", waddr, wdata, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_waddr", 32'(waddr), 32'(e.a));
        chk("sb_wdata", wdata, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // pipeline write, two b pushes in order, r0 handling
    vt[0]  = mk(1, 5'd3, 32'h1234, 0, 5'd0, 32'h0,  5'd0, 5'd0, 0, 3'd0, 1, 0, 0);
    vt[1]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd0, 5'd0, 1, 3'd0, 1, 0, 0);
    vt[2]  = mk(0, 5'd0, 32'h0,    1, 5'd5, 32'hA,  5'd0, 5'd0, 0, 3'd0, 1, 0, 0);
    vt[3]  = mk(0, 5'd0, 32'h0,    1, 5'd6, 32'hB,  5'd6, 5'd0, 0, 3'd1, 1, 0, 0);
    vt[4]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd6, 5'd5, 1, 3'd1, 1, 1, 0);
    vt[5]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd6, 5'd0, 1, 3'd0, 1, 0, 0);
    vt[6]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd0, 5'd0, 0, 3'd0, 1, 0, 0);
    vt[7]  = mk(1, 5'd0, 32'h55,   1, 5'd0, 32'h77, 5'd0, 5'd0, 0, 3'd0, 1, 0, 0);
    vt[8]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd0, 5'd0, 0, 3'd1, 1, 0, 0);
    vt[9]  = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd0, 5'd0, 0, 3'd0, 1, 0, 0);
    vt[10] = mk(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd0, 5'd0, 0, 3'd0, 1, 0, 0);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].pw, vt[i].pa, vt[i].pd, vt[i].bv, vt[i].ba, vt[i].bd);
      raddr1 = vt[i].r1;
      raddr2 = vt[i].r2;
      if (vt[i].pw && vt[i].pa != 5'd0) sb.push_back(mkw(vt[i].pa, vt[i].pd));
      if (vt[i].bv && vt[i].ba != 5'd0) sb.push_back(mkw(vt[i].ba, vt[i].bd));
      smp();
      chk($sformatf("v%0d_we", i), 32'(we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_pend1", i), 32'(pend1), 32'(vt[i].e_p1));
      chk($sformatf("v%0d_pend2", i), 32'(pend2), 32'(vt[i].e_p2));
      nxt();
    end
    idle();

    // fill while the pipeline owns the port, then drain in order
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'(c + 1), 32'(100 + c), 1'b1, 5'(8 + c), 32'(200 + c));
      sb.push_back(mkw(5'(c + 1), 32'(100 + c)));
      smp();
      chk($sformatf("fill%0d_count", c), 32'(count), 32'(c));
      chk($sformatf("fill%0d_b_ready", c), 32'(b_ready), 32'd1);
      nxt();
    end
    for (int c = 0; c < 4; c++) sb.push_back(mkw(5'(8 + c), 32'(200 + c)));
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'd999);
    smp();
    chk("full_count", 32'(count), 32'd4);
    chk("full_b_ready", 32'(b_ready), 32'd0);
    nxt();
    idle();
    smp();
    chk("drain_count", 32'(count), 32'd3);
    chk("drain_b_ready", 32'(b_ready), 32'd1);
    nxt();
    repeat (2) begin smp(); nxt(); end
    smp();
    chk("drained_count", 32'(count), 32'd0);
    nxt();
    smp();
    chk("drained_we", 32'(we), 32'd0);
    nxt();

    // squash of a queued entry by a younger pipeline write
    drive(1'b1, 5'd2, 32'h33, 1'b1, 5'd7, 32'h11);
    sb.push_back(mkw(5'd2, 32'h33));
    smp(); nxt();
    drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0);
    raddr1 = 5'd7;
    sb.push_back(mkw(5'd7, 32'h22));
    smp();
    chk("sq_pend_before", 32'(pend1), 32'd1);
    chk("sq_count1", 32'(count), 32'd1);
    nxt();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    smp();
    chk("sq_pend_after", 32'(pend1), 32'd0);
    chk("sq_count2", 32'(count), 32'd1);
    chk("sq_p_write", 32'(we), 32'd1);
    nxt();
    smp();
    chk("sq_pop_we", 32'(we), 32'd0);
    chk("sq_count3", 32'(count), 32'd0);
    nxt();

    // squash of an entry pushed in the same cycle
    idle();
    drive(1'b1, 5'd9, 32'h44, 1'b1, 5'd9, 32'h55);
    raddr2 = 5'd9;
    sb.push_back(mkw(5'd9, 32'h44));
    smp(); nxt();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    smp();
    chk("sqp_pend2", 32'(pend2), 32'd0);
    chk("sqp_count", 32'(count), 32'd1);
    nxt();
    smp();
    chk("sqp_pop_we", 32'(we), 32'd0);
    chk("sqp_count2", 32'(count), 32'd0);
    nxt();

    // reset with three live entries queued
    idle();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd1, 32'(300 + c), 1'b1, 5'(12 + c), 32'(400 + c));
      sb.push_back(mkw(5'd1, 32'(300 + c)));
      smp(); nxt();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    raddr1 = 5'd13;
    raddr2 = 5'd14;
    rst = 1'b1;
    smp();
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_pend1", 32'(pend1), 32'd1);
    chk("pre_rst_pend2", 32'(pend2), 32'd1);
    nxt();
    rst = 1'b0;
    smp();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_pend1", 32'(pend1), 32'd0);
    chk("rst_pend2", 32'(pend2), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    nxt();
    idle();
    repeat (6) begin smp(); nxt(); end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
